lsl_seq: RTL and testbench

LSL_SEQ -- requirements
Module: lsl_seq

---
 rtl/alu_pkg.sv | 15 +
 rtl/lsl_seq_if.sv | 34 +++
 rtl/lsl_seq.sv | 75 +++++++
 tb/tb_lsl_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and the sequential shifter state type
// Contents:
//   ALU_WIDTH   default datapath width (32)
//   lsl_state_t IDLE / SHIFT / DONE states of the sequential left shifter
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lsl_state_t;

endpackage

// File: rtl/lsl_seq_if.sv
// rtl/lsl_seq_if.sv - request/result bundle for the sequential left shifter
// Signals:
//   start   request pulse, sampled only while the shifter is idle
//   num     operand, captured on the accepted start edge
//   shifts  left-shift amount 0..WIDTH-1, captured with num
//   shifted registered result (zeros enter at the LSB)
//   c_out   registered carry: last bit shifted out of the MSB
//   busy    operation in progress
//   done    one-cycle pulse marking shifted/c_out valid
// Modports: master drives the request, slave is the shifter.
interface lsl_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             start;
    logic [WIDTH-1:0] num;
    logic [SHW-1:0]   shifts;
    logic [WIDTH-1:0] shifted;
    logic             c_out;
    logic             busy;
    logic             done;

    modport master (
        output start, num, shifts,
        input  shifted, c_out, busy, done
    );

    modport slave (
        input  start, num, shifts,
        output shifted, c_out, busy, done
    );
endinterface

// File: rtl/lsl_seq.sv
// rtl/lsl_seq.sv - sequential logical-shift-left unit, one bit per clock
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears state, acc, cnt and carry
//   bus  lsl_seq_if slave: start/num/shifts in, shifted/c_out/busy/done out
// An accepted start loads the operand; SHIFT moves it left one bit per edge
// until the count is used up, then DONE pulses for a single cycle.
module lsl_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    lsl_seq_if.slave  bus
);

    lsl_state_t       state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [SHW-1:0]   cnt, cnt_nxt;
    logic             carry, carry_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            carry <= carry_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        carry_nxt = carry;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt   = bus.num;
                    cnt_nxt   = bus.shifts;
                    carry_nxt = 1'b0;
                    // A zero-length shift skips SHIFT so cnt never wraps.
                    state_nxt = (bus.shifts != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                acc_nxt   = {acc[WIDTH-2:0], 1'b0};
                carry_nxt = acc[WIDTH-1];
                cnt_nxt   = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.shifted = acc;
    assign bus.c_out   = carry;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_lsl_seq.sv
// tb/tb_lsl_seq.sv - directed self-checking bench for lsl_seq
module tb_lsl_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsl_seq_if #(.WIDTH(32)) bus ();

    lsl_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Launches one operation once the unit is idle and waits for done.
    // edges counts clock edges from (and including) the edge sampling start.
    task automatic run_op(input logic [31:0] n, input logic [4:0] s,
                          output int edges, output logic [31:0] res,
                          output logic c, output bit ok);
        int guard;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        bus.num    = n;
        bus.shifts = s;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 1;
        while (!bus.done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        ok  = bus.done;
        res = bus.shifted;
        c   = bus.c_out;
    endtask

    task automatic test_reset();
        bus.start  = 1'b0;
        bus.num    = 32'h1234_5678;
        bus.shifts = 5'd3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.shifted !== 32'h0) begin
            fails++; $display("FAIL reset_shifted got=%h exp=%h", bus.shifted, 32'h0);
        end
        tests++;
        if ({bus.c_out, bus.busy, bus.done} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got c/b/d=%b exp=000", {bus.c_out, bus.busy, bus.done});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vec(input string name, input logic [31:0] n, input logic [4:0] s,
                            input int exp_edges, input logic [31:0] exp_res, input logic exp_c);
        int edges; logic [31:0] res; logic c; bit ok;
        run_op(n, s, edges, res, c, ok);
        tests++;
        if (!ok || edges !== exp_edges) begin
            fails++; $display("FAIL %s_latency got=%0d done=%0b exp=%0d", name, edges, ok, exp_edges);
        end
        tests++;
        if (res !== exp_res) begin
            fails++; $display("FAIL %s_shifted got=%h exp=%h", name, res, exp_res);
        end
        tests++;
        if (c !== exp_c) begin
            fails++; $display("FAIL %s_c_out got=%b exp=%b", name, c, exp_c);
        end
        // done is a single-cycle pulse; the result then holds in IDLE
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL %s_pulse got done=%b busy=%b exp done=0 busy=0", name, bus.done, bus.busy);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.shifted !== exp_res || bus.c_out !== exp_c) begin
            fails++; $display("FAIL %s_hold got=%h/%b exp=%h/%b", name, bus.shifted, bus.c_out, exp_res, exp_c);
        end
    endtask

    task automatic test_busy_ignore();
        int edges; int done_cnt; int first_done; logic [31:0] res; logic c;
        done_cnt = 0; first_done = 0; res = '0; c = 1'b0;
        @(negedge clk);
        bus.num = 32'hFFFF_FFFF; bus.shifts = 5'd8; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 1;
        while (edges < 20) begin
            if (edges == 2) begin
                bus.start = 1'b1; bus.num = 32'h0000_0001; bus.shifts = 5'd1;
            end
            @(posedge clk); #1;
            edges++;
            if (edges == 3) begin
                bus.start = 1'b0; bus.num = 32'h5A5A_5A5A; bus.shifts = 5'd2;
            end
            if (bus.done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = edges; res = bus.shifted; c = bus.c_out;
                end
            end
        end
        tests++;
        if (done_cnt !== 1 || first_done !== 9) begin
            fails++; $display("FAIL busy_done got pulses=%0d at=%0d exp pulses=1 at=9", done_cnt, first_done);
        end
        tests++;
        if (res !== 32'hFFFF_FF00 || c !== 1'b1) begin
            fails++; $display("FAIL busy_result got=%h/%b exp=%h/%b", res, c, 32'hFFFF_FF00, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int edges; int done_cnt; logic [31:0] res; logic c; bit ok;
        done_cnt = 0;
        @(negedge clk);
        bus.num = 32'hFFFF_FFFF; bus.shifts = 5'd10; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        if (bus.done) done_cnt++;
        #1 rst = 1'b1;
        #1;
        tests++;
        if (bus.shifted !== 32'h0 || {bus.c_out, bus.busy, bus.done} !== 3'b000) begin
            fails++; $display("FAIL rst_mid_async got=%h c/b/d=%b exp=0 000", bus.shifted, {bus.c_out, bus.busy, bus.done});
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        tests++;
        if (done_cnt !== 0) begin
            fails++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt);
        end
        run_op(32'h1, 5'd2, edges, res, c, ok);
        tests++;
        if (!ok || edges !== 3 || res !== 32'h4 || c !== 1'b0) begin
            fails++; $display("FAIL rst_restart got edges=%0d res=%h c=%b exp edges=3 res=%h c=0", edges, res, c, 32'h4);
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2; logic [31:0] r1, r2; logic c1, c2; bit ok1, ok2;
        run_op(32'h0000_00F0, 5'd4, e1, r1, c1, ok1);
        // run_op waits only for the DONE cycle to pass before issuing
        run_op(32'h4000_0000, 5'd2, e2, r2, c2, ok2);
        tests++;
        if (!ok1 || e1 !== 5 || r1 !== 32'h0000_0F00 || c1 !== 1'b0) begin
            fails++; $display("FAIL b2b_first got edges=%0d res=%h c=%b exp edges=5 res=%h c=0", e1, r1, c1, 32'h0000_0F00);
        end
        tests++;
        if (!ok2 || e2 !== 3 || r2 !== 32'h0000_0000 || c2 !== 1'b1) begin
            fails++; $display("FAIL b2b_second got edges=%0d res=%h c=%b exp edges=3 res=%h c=1", e2, r2, c2, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_vec("shl4",  32'h0000_0001, 5'd4,  5,  32'h0000_0010, 1'b0);
        test_vec("shl1",  32'h8000_0001, 5'd1,  2,  32'h0000_0002, 1'b1);
        test_vec("shl0",  32'hDEAD_BEEF, 5'd0,  1,  32'hDEAD_BEEF, 1'b0);
        test_vec("shl31", 32'h0000_0003, 5'd31, 32, 32'h8000_0000, 1'b1);
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
